// File: rtl/uart_cmd_link.sv
// rtl/uart_cmd_link.sv - host command UART: decodes 'A'/'S' packets, transmits a TX_BYTES response MSB byte first
// Optional macro UART_CMD_PARITY_EN adds one even-parity bit after data bit 7 on RX and TX.
module uart_cmd_link #(
    parameter int CLK          = 60,
    parameter int BAUD         = 921600,
    parameter int TX_BYTES     = 2,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                  clk_PSRAM,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    input  logic                  send_uart,
    input  logic [8*TX_BYTES-1:0] send_msg,
    output logic                  tx_busy,
    output logic                  flag_end_tx,
    output logic [7:0]            trigger,
    output logic [12:0]           threshold,
    output logic [21:0]           samples_after,
    output logic [21:0]           samples_before,
    output logic                  flag_acq,
    output logic                  flag_debug,
    output logic                  rx_error
);
    localparam int DELAY     = (CLK * 1000000) / BAUD;
    localparam int HALF      = DELAY / 2;
    localparam int TO_CYCLES = TIMEOUT_BITS * DELAY;
    localparam int CW        = $clog2(DELAY + 1);
    localparam int TW        = $clog2(TO_CYCLES + 1);

    localparam logic [CW-1:0] DLY_M1    = CW'(DELAY - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(TX_BYTES - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    rx_state_t       rx_state;
    logic [1:0]      rx_sync;
    logic            rx_line;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            byte_valid;
    logic [3:0]      pkt_cnt;
    logic [TW-1:0]   to_cnt;
    logic [7:0]      rx_buf [0:9];
`ifdef UART_CMD_PARITY_EN
    logic            rx_par_err;
`endif

    tx_state_t             tx_state;
    logic [CW-1:0]         tx_cnt;
    logic [2:0]            tx_bit;
    logic [2:0]            tx_idx;
    logic [7:0]            tx_byte;
    logic [8*TX_BYTES-1:0] tx_shift;
`ifdef UART_CMD_PARITY_EN
    logic                  tx_par;
`endif

    assign rx_line = rx_sync[1];

    // RX deserialiser, packet parser and inter-byte timeout share one state register set
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            rx_sync        <= 2'b11;
            rx_state       <= RX_IDLE;
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            byte_valid     <= 1'b0;
            pkt_cnt        <= '0;
            to_cnt         <= '0;
            trigger        <= '0;
            threshold      <= '0;
            samples_after  <= '0;
            samples_before <= '0;
            flag_acq       <= 1'b0;
            flag_debug     <= 1'b0;
            rx_error       <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            rx_par_err     <= 1'b0;
`endif
        end else begin
            rx_sync    <= {rx_sync[0], uart_rx};
            byte_valid <= 1'b0;
            flag_acq   <= 1'b0;
            flag_debug <= 1'b0;
            rx_error   <= 1'b0;

            if (byte_valid) begin
                to_cnt <= '0;
                if (pkt_cnt == 4'd0) begin
                    if (rx_shift == 8'h53) begin
                        flag_debug <= 1'b1;
                    end else if (rx_shift == 8'h41) begin
                        rx_buf[0] <= rx_shift;
                        pkt_cnt   <= 4'd1;
                    end
                end else begin
                    rx_buf[pkt_cnt] <= rx_shift;
                    if (pkt_cnt == 4'd9) begin
                        trigger        <= rx_buf[1];
                        threshold      <= {rx_buf[2][4:0], rx_buf[3]};
                        samples_after  <= {rx_buf[4][5:0], rx_buf[5], rx_buf[6]};
                        samples_before <= {rx_buf[7][5:0], rx_buf[8], rx_shift};
                        flag_acq       <= 1'b1;
                        pkt_cnt        <= 4'd0;
                    end else begin
                        pkt_cnt <= pkt_cnt + 4'd1;
                    end
                end
            end else if (pkt_cnt != 4'd0) begin
                if (to_cnt == TO_LAST) begin
                    rx_error <= 1'b1;
                    pkt_cnt  <= 4'd0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            case (rx_state)
                RX_IDLE: begin
                    if (!rx_line) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DLY_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_line, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                            rx_state <= RX_PAR;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_CMD_PARITY_EN
                RX_PAR: begin
                    if (rx_cnt == DLY_M1) begin
                        rx_cnt     <= '0;
                        rx_par_err <= rx_line ^ (^rx_shift);
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt == DLY_M1) begin
                        rx_cnt <= '0;
`ifdef UART_CMD_PARITY_EN
                        if (rx_line && !rx_par_err) begin
`else
                        if (rx_line) begin
`endif
                            byte_valid <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end else begin
                            rx_error <= 1'b1;
                            pkt_cnt  <= 4'd0;
                            to_cnt   <= '0;
                            rx_state <= RX_WAIT;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (rx_line) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // TX serialiser: whole response word is latched at acceptance, then peeled off MSB byte first
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_idx      <= '0;
            tx_byte     <= '0;
            tx_shift    <= '0;
            uart_tx     <= 1'b1;
            tx_busy     <= 1'b0;
            flag_end_tx <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            flag_end_tx <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (send_uart && !flag_end_tx) begin
                        tx_byte  <= send_msg[8*TX_BYTES-1 -: 8];
                        tx_shift <= send_msg << 8;
`ifdef UART_CMD_PARITY_EN
                        tx_par   <= ^send_msg[8*TX_BYTES-1 -: 8];
`endif
                        tx_idx   <= '0;
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == DLY_M1) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_byte[0];
                        tx_byte  <= tx_byte >> 1;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == DLY_M1) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                            uart_tx  <= tx_par;
                            tx_state <= TX_PAR;
`else
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
`endif
                        end else begin
                            uart_tx <= tx_byte[0];
                            tx_byte <= tx_byte >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_CMD_PARITY_EN
                TX_PAR: begin
                    if (tx_cnt == DLY_M1) begin
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt == DLY_M1) begin
                        tx_cnt <= '0;
                        if (tx_idx == LAST_BYTE) begin
                            tx_busy     <= 1'b0;
                            flag_end_tx <= 1'b1;
                            tx_state    <= TX_IDLE;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            tx_byte  <= tx_shift[8*TX_BYTES-1 -: 8];
                            tx_shift <= tx_shift << 8;
`ifdef UART_CMD_PARITY_EN
                            tx_par   <= ^tx_shift[8*TX_BYTES-1 -: 8];
`endif
                            uart_tx  <= 1'b0;
                            tx_state <= TX_START;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_link.sv
// tb/tb_uart_cmd_link.sv - randomized self-checking bench for uart_cmd_link against a packet-level model
`timescale 1ns/1ps
module tb_uart_cmd_link;
    localparam int DELAY    = (60 * 1000000) / 921600;
    localparam int TX_BYTES = 2;
`ifdef UART_CMD_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  uart_rx;
    logic                  uart_tx;
    logic                  send_uart;
    logic [8*TX_BYTES-1:0] send_msg;
    logic                  tx_busy;
    logic                  flag_end_tx;
    logic [7:0]            trigger;
    logic [12:0]           threshold;
    logic [21:0]           samples_after;
    logic [21:0]           samples_before;
    logic                  flag_acq;
    logic                  flag_debug;
    logic                  rx_error;

    always #5 clk = ~clk;

    uart_cmd_link #(.CLK(60), .BAUD(921600), .TX_BYTES(TX_BYTES), .TIMEOUT_BITS(32)) dut (
        .clk_PSRAM(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .send_uart(send_uart), .send_msg(send_msg), .tx_busy(tx_busy), .flag_end_tx(flag_end_tx),
        .trigger(trigger), .threshold(threshold), .samples_after(samples_after),
        .samples_before(samples_before), .flag_acq(flag_acq), .flag_debug(flag_debug),
        .rx_error(rx_error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int acq_hi = 0, dbg_hi = 0, err_hi = 0, end_hi = 0, busy_hi = 0;
    longint exp_trig = 0, exp_thr = 0, exp_sa = 0, exp_sb = 0;

    always @(negedge clk) begin
        acq_hi  += int'(flag_acq);
        dbg_hi  += int'(flag_debug);
        err_hi  += int'(rx_error);
        end_hi  += int'(flag_end_tx);
        busy_hi += int'(tx_busy);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        tick(DELAY);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DELAY);
        end
`ifdef UART_CMD_PARITY_EN
        uart_rx = ^b;
        tick(DELAY);
`endif
        uart_rx = !bad_stop;
        tick(DELAY);
        uart_rx = 1'b1;
        tick(4);
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_trigger"}, longint'(trigger), exp_trig);
        check({tag, "_threshold"}, longint'(threshold), exp_thr);
        check({tag, "_samples_after"}, longint'(samples_after), exp_sa);
        check({tag, "_samples_before"}, longint'(samples_before), exp_sb);
    endtask

    // Field layout taken straight from the packet definition, by arithmetic on byte values
    task automatic send_packet(input string tag, input logic [7:0] p [10]);
        int a0, e0;
        a0 = acq_hi;
        e0 = err_hi;
        for (int i = 0; i < 10; i++) rx_send(p[i], 1'b0);
        exp_trig = p[1];
        exp_thr  = (p[2] % 32) * 256 + p[3];
        exp_sa   = (p[4] % 64) * 65536 + p[5] * 256 + p[6];
        exp_sb   = (p[7] % 64) * 65536 + p[8] * 256 + p[9];
        check({tag, "_acq_pulse"}, acq_hi - a0, 1);
        check({tag, "_no_error"}, err_hi - e0, 0);
        check_cfg(tag);
    endtask

    task automatic tx_check(input string tag, input logic [15:0] msg, input bit poke);
        int e0, b0;
        logic line [TX_BYTES*FRAME];
        logic [7:0] got, want;
        e0 = end_hi;
        b0 = busy_hi;
        send_msg  = msg;
        send_uart = 1'b1;
        tick(1);
        send_uart = 1'b0;
        check({tag, "_start_next_cycle"}, longint'(uart_tx), 0);
        check({tag, "_busy"}, longint'(tx_busy), 1);
        tick(DELAY / 2);
        for (int g = 0; g < TX_BYTES * FRAME; g++) begin
            line[g] = uart_tx;
            if (poke && g == 3) begin
                send_msg  = ~msg;
                send_uart = 1'b1;
            end else begin
                send_uart = 1'b0;
            end
            if (g != TX_BYTES * FRAME - 1) tick(DELAY);
        end
        send_uart = 1'b0;
        tick(DELAY / 2 + 8);
        for (int k = 0; k < TX_BYTES; k++) begin
            want = 8'((msg >> (8 * (TX_BYTES - 1 - k))) & 16'hFF);
            for (int i = 0; i < 8; i++) got[i] = line[k * FRAME + 1 + i];
            check({tag, "_start_bit"}, longint'(line[k * FRAME]), 0);
            check({tag, "_data_byte"}, longint'(got), longint'(want));
`ifdef UART_CMD_PARITY_EN
            check({tag, "_parity"}, longint'(line[k * FRAME + 9]), longint'(^want));
`endif
            check({tag, "_stop_bit"}, longint'(line[k * FRAME + FRAME - 1]), 1);
        end
        check({tag, "_busy_cycles"}, busy_hi - b0, TX_BYTES * FRAME * DELAY);
        check({tag, "_end_pulse"}, end_hi - e0, 1);
        tick(100);
        check({tag, "_idle_after"}, busy_hi - b0, TX_BYTES * FRAME * DELAY);
        check({tag, "_line_idle"}, longint'(uart_tx), 1);
    endtask

    task automatic wait_end(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * TX_BYTES * FRAME * DELAY && !seen; i++) begin
            if (flag_end_tx) seen = 1'b1;
            else tick(1);
        end
        check({tag, "_end_seen"}, longint'(seen), 1);
    endtask

    initial begin
        logic [7:0] p [10];
        logic [7:0] junk;
        int a0, d0, e0;

        rst = 1'b1; uart_rx = 1'b1; send_uart = 1'b0; send_msg = '0;
        tick(5);
        rst = 1'b0;
        tick(1000);
        check("reset_uart_tx", longint'(uart_tx), 1);
        check("reset_tx_busy", longint'(tx_busy), 0);
        check("reset_pulses", acq_hi + dbg_hi + err_hi + end_hi + busy_hi, 0);
        check_cfg("reset");

        p = '{8'h41, 8'h54, 8'h0F, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20};
        send_packet("pkt_basic", p);
        check("pkt_basic_const_thr", longint'(threshold), 13'h0FFF);

        d0 = dbg_hi; a0 = acq_hi;
        rx_send(8'h53, 1'b0);
        check("debug_pulse", dbg_hi - d0, 1);
        check("debug_no_acq", acq_hi - a0, 0);
        p[1] = 8'h21;
        send_packet("pkt_after_debug", p);

        e0 = err_hi; d0 = dbg_hi;
        uart_rx = 1'b0; tick(10); uart_rx = 1'b1; tick(200);
        check("glitch_no_error", err_hi - e0, 0);
        check("glitch_no_debug", dbg_hi - d0, 0);

        e0 = err_hi; a0 = acq_hi;
        rx_send(8'h41, 1'b0); rx_send(8'h54, 1'b0); rx_send(8'h01, 1'b0);
        tick(40 * DELAY);
        check("timeout_error", err_hi - e0, 1);
        check("timeout_no_acq", acq_hi - a0, 0);
        check_cfg("timeout_hold");
        p[2] = 8'hE3;
        send_packet("pkt_after_timeout", p);

        e0 = err_hi; a0 = acq_hi;
        rx_send(8'h41, 1'b0); rx_send(8'h11, 1'b0); rx_send(8'h22, 1'b0);
        rx_send(8'h33, 1'b1);
        tick(50);
        check("frame_error", err_hi - e0, 1);
        check("frame_no_acq", acq_hi - a0, 0);
        check_cfg("frame_hold");
        p[3] = 8'h5C;
        send_packet("pkt_after_frame", p);

        d0 = dbg_hi; a0 = acq_hi; e0 = err_hi;
        for (int j = 0; j < 2; j++) begin
            do junk = 8'($urandom); while (junk == 8'h41 || junk == 8'h53);
            rx_send(junk, 1'b0);
        end
        tick(3000);
        check("junk_ignored", (dbg_hi - d0) + (acq_hi - a0) + (err_hi - e0), 0);

        for (int r = 0; r < 2; r++) begin
            p[0] = 8'h41;
            for (int i = 1; i < 10; i++) p[i] = 8'($urandom);
            send_packet("pkt_random", p);
        end

        tx_check("tx_a55a", 16'hA55A, 1'b1);
        tx_check("tx_random", 16'($urandom), 1'b1);

        p[0] = 8'h41;
        for (int i = 1; i < 10; i++) p[i] = 8'($urandom);
        fork
            send_packet("pkt_concurrent", p);
            tx_check("tx_concurrent", 16'($urandom), 1'b0);
        join

        send_msg  = 16'h1234;
        send_uart = 1'b1;
        tick(1);
        wait_end("hold_first");
        tick(1);
        check("end_cycle_send_ignored", longint'(tx_busy), 0);
        tick(1);
        check("accept_after_end_busy", longint'(tx_busy), 1);
        check("accept_after_end_start", longint'(uart_tx), 0);
        send_uart = 1'b0;
        wait_end("hold_second");
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
